mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between the Fetch stage (instruction reads) and the Memory stage (data reads/writes) of the Y86-64 pipeline.
- Sequences one outstanding transaction at a time against a variable-latency memory (req/ack handshake).
- Returns data and address-error status to the requesting stage.
- Raises per-stage stall requests that pipeline control ORs into F_stall/D_stall and M/W handling.

Parameters:
- ADDR_W, 64, address width in bits.
- DATA_W, 64, data width of the memory port and of both stage interfaces.
- MEM_SIZE, 4096, bytes; any address >= MEM_SIZE is an address error.
- MAX_M_STREAK, 4, consecutive M grants allowed while fetch waits; must be >= 1.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- f_req  in  1  fetch read request; held with f_addr until f_done.
- f_addr  in  ADDR_W  fetch address.
- f_rdata  out  DATA_W  fetch read data; valid when f_done.
- f_err  out  1  fetch address error; valid when f_done.
- f_done  out  1  one-cycle completion pulse for fetch.
- f_mem_stall  out  1  f_req & ~f_done.
- m_req  in  1  memory-stage request; held with m_we/m_addr/m_wdata until m_done.
- m_we  in  1  1 = write, 0 = read.
- m_addr  in  ADDR_W  data address.
- m_wdata  in  DATA_W  write data.
- m_rdata  out  DATA_W  read data; valid when m_done and ~m_we.
- m_err  out  1  data address error (dmem_error); valid when m_done.
- m_done  out  1  one-cycle completion pulse for memory stage.
- m_mem_stall  out  1  m_req & ~m_done.
- mem_req  out  1  memory request, held high until mem_ack.
- mem_we  out  1  write enable to memory.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_ack  in  1  one-cycle completion from memory.
- mem_rdata  in  DATA_W  read data, valid with mem_ack.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=IDLE, streak=0.
  - All mem_* outputs 0; all done/err pulses 0.
  - f_rdata and m_rdata cleared to 0.
- States:
  - IDLE: no transaction outstanding. Pick a winner from the pending requests:
    - M wins if m_req and (~f_req or streak < MAX_M_STREAK).
    - Otherwise F wins if f_req.
  - Winner address out of range (addr >= MEM_SIZE):
    - Respond on the next cycle with done=1, err=1, rdata=0.
    - No mem_req is issued; state stays IDLE.
  - Winner in range:
    - Register the address, we and wdata onto mem_*.
    - Assert mem_req from the next cycle.
    - Go to BUSY_F or BUSY_M.
  - BUSY_x:
    - Hold mem_req and all mem_* stable until mem_ack.
    - On mem_ack: pulse x_done (registered, next cycle), err=0. Load x_rdata from mem_rdata, or hold the previous value for a write. Return to IDLE.
- Minimum latency: request sampled in cycle N; mem_req high in N+1; with ack in N+1, done in N+2. An error response has done in N+1.
- Back-to-back: the IDLE cycle after done may grant a new request. The requester must drop or advance its req in the cycle done is seen. A req still high one cycle after done counts as a new request.
- Streak counter:
  - Increments on each M grant while f_req=1, saturating at MAX_M_STREAK.
  - Clears on any F grant, or on any M grant while f_req=0.
  - Guarantees fetch waits at most MAX_M_STREAK M transactions.
- Writes:
  - Performed only when m_we=1 and the address is in range.
  - An out-of-range write never reaches memory.
- Spurious mem_ack in IDLE is ignored: no done, no state change.
- Reset mid-transaction:
  - Abandons the transaction: mem_req drops, and no done pulse is produced for it.
  - An ack arriving after reset is ignored per the IDLE rule.
- Requests changing while in BUSY are a protocol violation. A simulation assertion flags an address or we change while req is high and done is low.
- Stalls are combinational from req and the registered done. Both may be 1 simultaneously; pipeline control resolves them, M stall taking precedence.

Decomposition:
- Shared package holds:
  - the state encoding (ARB_IDLE, ARB_BUSY_F, ARB_BUSY_M);
  - the owner encoding (OWN_F, OWN_M);
  - stat codes aligned with the pipeline (SAOK=2'b00, SADR=2'b10), so f_err/m_err map directly into f_stat/m_stat.
- Sub-module: arb_prio_streak. Holds the streak counter and produces the grant decision (gnt_f, gnt_m) from f_req, m_req and streak. Keeps the arbitration policy separately testable.
- The top level holds the FSM, the address-range check, the output registers and the stall logic.

Test Plan:
- Single fetch: f_req=1, f_addr=0x10, memory acks 1 cycle after mem_req with rdata=0x30F2_0A00 → f_done at the req cycle +2; f_rdata=0x30F2_0A00; f_err=0; f_mem_stall=1 until done.
- Simultaneous f_req and m_req (read at 0x200) → M granted first; f_mem_stall stays 1 through the M transaction; F granted in the IDLE cycle after m_done.
- Starvation guard with MAX_M_STREAK=4: m_req held continuously with new addresses plus steady f_req → exactly 4 M completions, then one F completion, then M resumes.
- Address error: m_req, m_we=1, m_addr=0x1000 (=MEM_SIZE) → no mem_req ever; m_done=1 and m_err=1 on the next cycle. A subsequent read of 0x0FF8 succeeds with m_err=0.
- Slow memory: ack delayed 7 cycles → mem_req/mem_addr stable for all 7 cycles; stall held; exactly one done pulse.
- Reset mid-transaction: assert rst_n=0 while in BUSY_M, then ack arrives 2 cycles after release → no m_done; state IDLE; a following f_req completes normally.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the unified memory-port arbiter: FSM states, owners and
// pipeline-aligned status codes.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_BUSY_F = 2'd1,
        ARB_BUSY_M = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_F = 1'b0,
        OWN_M = 1'b1
    } owner_e;

    typedef logic [1:0] stat_t;

    localparam stat_t SAOK = 2'b00;
    localparam stat_t SADR = 2'b10;

    function automatic stat_t range_stat(input logic addr_bad);
        return addr_bad ? SADR : SAOK;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_arb_prio_streak.sv
// Fetch/memory grant policy: M has priority, but fetch is guaranteed a grant
// after at most MAX_M_STREAK consecutive M grants.
module arb_prio_streak #(
    parameter int unsigned MAX_M_STREAK = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic f_req_i,
    input  logic m_req_i,
    output logic gnt_f_o,
    output logic gnt_m_o
);

    localparam int unsigned SW = $clog2(MAX_M_STREAK + 1);
    localparam logic [SW-1:0] StreakMax = SW'(MAX_M_STREAK);

    logic [SW-1:0] streak_q, streak_d;

    always_comb begin
        gnt_m_o  = en_i & m_req_i & (~f_req_i | (streak_q < StreakMax));
        gnt_f_o  = en_i & f_req_i & ~gnt_m_o;
        streak_d = streak_q;
        if (gnt_f_o) begin
            streak_d = '0;
        end else if (gnt_m_o) begin
            // Only count M grants that actually made fetch wait.
            if (!f_req_i) begin
                streak_d = '0;
            end else if (streak_q < StreakMax) begin
                streak_d = streak_q + SW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory port between Fetch and Memory stages,
// one outstanding transaction at a time, with range checking and stall outputs.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W       = 64,
    parameter int unsigned DATA_W       = 64,
    parameter int unsigned MEM_SIZE     = 4096,
    parameter int unsigned MAX_M_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic [DATA_W-1:0] f_rdata,
    output logic              f_err,
    output logic              f_done,
    output logic              f_mem_stall,
    input  logic              m_req,
    input  logic              m_we,
    input  logic [ADDR_W-1:0] m_addr,
    input  logic [DATA_W-1:0] m_wdata,
    output logic [DATA_W-1:0] m_rdata,
    output logic              m_err,
    output logic              m_done,
    output logic              m_mem_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [ADDR_W-1:0] MemLimit = ADDR_W'(MEM_SIZE);

    arb_state_e        state_q, state_d;
    logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] f_rdata_q, f_rdata_d, m_rdata_q, m_rdata_d;
    logic              f_done_q, f_done_d, f_err_q, f_err_d;
    logic              m_done_q, m_done_d, m_err_q, m_err_d;

    logic              arb_en, gnt_f, gnt_m, addr_bad, stat_err;
    owner_e            win_own;
    logic [ADDR_W-1:0] sel_addr;

    // A requester still sees its done pulse this cycle; its req is not new yet.
    assign arb_en   = (state_q == ARB_IDLE) & ~f_done_q & ~m_done_q;
    assign win_own  = gnt_m ? OWN_M : OWN_F;
    assign sel_addr = (win_own == OWN_M) ? m_addr : f_addr;
    assign addr_bad = (sel_addr >= MemLimit);
    assign stat_err = (range_stat(addr_bad) == SADR);

    arb_prio_streak #(
        .MAX_M_STREAK (MAX_M_STREAK)
    ) u_prio (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .en_i    (arb_en),
        .f_req_i (f_req),
        .m_req_i (m_req),
        .gnt_f_o (gnt_f),
        .gnt_m_o (gnt_m)
    );

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        f_rdata_d   = f_rdata_q;
        m_rdata_d   = m_rdata_q;
        f_done_d    = 1'b0;
        f_err_d     = 1'b0;
        m_done_d    = 1'b0;
        m_err_d     = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                if (gnt_f || gnt_m) begin
                    if (stat_err) begin
                        if (win_own == OWN_M) begin
                            m_done_d  = 1'b1;
                            m_err_d   = 1'b1;
                            m_rdata_d = '0;
                        end else begin
                            f_done_d  = 1'b1;
                            f_err_d   = 1'b1;
                            f_rdata_d = '0;
                        end
                    end else begin
                        mem_req_d   = 1'b1;
                        mem_we_d    = (win_own == OWN_M) & m_we;
                        mem_addr_d  = sel_addr;
                        mem_wdata_d = (win_own == OWN_M) ? m_wdata : '0;
                        state_d     = (win_own == OWN_M) ? ARB_BUSY_M : ARB_BUSY_F;
                    end
                end
            end
            ARB_BUSY_F: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    f_done_d  = 1'b1;
                    f_rdata_d = mem_rdata;
                    state_d   = ARB_IDLE;
                end
            end
            ARB_BUSY_M: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    m_done_d  = 1'b1;
                    if (!mem_we_q) begin
                        m_rdata_d = mem_rdata;
                    end
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ARB_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            f_rdata_q   <= '0;
            m_rdata_q   <= '0;
            f_done_q    <= 1'b0;
            f_err_q     <= 1'b0;
            m_done_q    <= 1'b0;
            m_err_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            f_rdata_q   <= f_rdata_d;
            m_rdata_q   <= m_rdata_d;
            f_done_q    <= f_done_d;
            f_err_q     <= f_err_d;
            m_done_q    <= m_done_d;
            m_err_q     <= m_err_d;
        end
    end

    assign f_rdata     = f_rdata_q;
    assign f_err       = f_err_q;
    assign f_done      = f_done_q;
    assign m_rdata     = m_rdata_q;
    assign m_err       = m_err_q;
    assign m_done      = m_done_q;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign f_mem_stall = f_req & ~f_done_q;
    assign m_mem_stall = m_req & ~m_done_q;

    // Requesters must hold their request steady until they see done.
    a_f_hold: assert property (@(posedge clk) disable iff (!rst_n)
        ($past(rst_n) && $past(f_req) && !$past(f_done) && f_req && !f_done)
            |-> $stable(f_addr));
    a_m_hold: assert property (@(posedge clk) disable iff (!rst_n)
        ($past(rst_n) && $past(m_req) && !$past(m_done) && m_req && !m_done)
            |-> ($stable(m_addr) && $stable(m_we)));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: hand-driven memory acks and
// hand-computed expected responses.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        f_req, m_req, m_we, mem_ack;
    logic [63:0] f_addr, m_addr, m_wdata, mem_rdata;
    logic [63:0] f_rdata, m_rdata, mem_addr, mem_wdata;
    logic        f_err, f_done, f_mem_stall, m_err, m_done, m_mem_stall, mem_req, mem_we;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .f_req       (f_req),
        .f_addr      (f_addr),
        .f_rdata     (f_rdata),
        .f_err       (f_err),
        .f_done      (f_done),
        .f_mem_stall (f_mem_stall),
        .m_req       (m_req),
        .m_we        (m_we),
        .m_addr      (m_addr),
        .m_wdata     (m_wdata),
        .m_rdata     (m_rdata),
        .m_err       (m_err),
        .m_done      (m_done),
        .m_mem_stall (m_mem_stall),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0; f_req = 1'b0; m_req = 1'b0; m_we = 1'b0; mem_ack = 1'b0;
        f_addr = '0; m_addr = '0; m_wdata = '0; mem_rdata = '0;
        tick(); tick();
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_mem_addr", mem_addr, 64'd0);
        chk("rst_f_done", 64'(f_done), 64'd0);
        chk("rst_m_done", 64'(m_done), 64'd0);
        chk("rst_f_rdata", f_rdata, 64'd0);
        chk("rst_m_rdata", m_rdata, 64'd0);
        rst_n = 1'b1;
        tick();

        // Single fetch, 1-cycle memory.
        f_req = 1'b1; f_addr = 64'h10;
        #1 chk("f1_stall_req", 64'(f_mem_stall), 64'd1);
        tick();
        chk("f1_mem_req", 64'(mem_req), 64'd1);
        chk("f1_mem_addr", mem_addr, 64'h10);
        chk("f1_mem_we", 64'(mem_we), 64'd0);
        chk("f1_no_done_yet", 64'(f_done), 64'd0);
        mem_ack = 1'b1; mem_rdata = 64'h30F2_0A00;
        tick();
        mem_ack = 1'b0;
        chk("f1_done", 64'(f_done), 64'd1);
        chk("f1_rdata", f_rdata, 64'h30F2_0A00);
        chk("f1_err", 64'(f_err), 64'd0);
        chk("f1_stall_done", 64'(f_mem_stall), 64'd0);
        chk("f1_mem_req_drop", 64'(mem_req), 64'd0);
        f_req = 1'b0;
        tick();
        chk("f1_done_pulse", 64'(f_done), 64'd0);

        // Simultaneous F and M: M first, F in the IDLE cycle after m_done.
        f_req = 1'b1; f_addr = 64'h20; m_req = 1'b1; m_we = 1'b0; m_addr = 64'h200;
        tick();
        chk("fm_mem_addr_m", mem_addr, 64'h200);
        chk("fm_f_stall", 64'(f_mem_stall), 64'd1);
        chk("fm_m_stall", 64'(m_mem_stall), 64'd1);
        mem_ack = 1'b1; mem_rdata = 64'hAAAA;
        tick();
        mem_ack = 1'b0;
        chk("fm_m_done", 64'(m_done), 64'd1);
        chk("fm_m_rdata", m_rdata, 64'hAAAA);
        chk("fm_f_stall_hold", 64'(f_mem_stall), 64'd1);
        m_req = 1'b0;
        tick();
        chk("fm_idle_gap", 64'(mem_req), 64'd0);
        tick();
        chk("fm_f_mem_req", 64'(mem_req), 64'd1);
        chk("fm_f_mem_addr", mem_addr, 64'h20);
        mem_ack = 1'b1; mem_rdata = 64'h5555;
        tick();
        mem_ack = 1'b0;
        chk("fm_f_done", 64'(f_done), 64'd1);
        chk("fm_f_rdata", f_rdata, 64'h5555);
        chk("fm_m_rdata_keep", m_rdata, 64'hAAAA);
        f_req = 1'b0;
        tick();

        // Starvation guard: 4 M completions, then F, then M resumes.
        f_req = 1'b1; f_addr = 64'h40; m_req = 1'b1; m_we = 1'b0; m_addr = 64'h300;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("sg_m_mem_req", 64'(mem_req), 64'd1);
            chk("sg_m_mem_addr", mem_addr, 64'h300 + 64'(8 * i));
            mem_ack = 1'b1; mem_rdata = 64'(i + 1);
            tick();
            mem_ack = 1'b0;
            chk("sg_m_done", 64'(m_done), 64'd1);
            chk("sg_f_not_done", 64'(f_done), 64'd0);
            chk("sg_m_rdata", m_rdata, 64'(i + 1));
            m_addr = m_addr + 64'd8;
            tick();
            chk("sg_gap", 64'(mem_req), 64'd0);
        end
        tick();
        chk("sg_f_mem_addr", mem_addr, 64'h40);
        mem_ack = 1'b1; mem_rdata = 64'hF00D;
        tick();
        mem_ack = 1'b0;
        chk("sg_f_done", 64'(f_done), 64'd1);
        chk("sg_m_not_done", 64'(m_done), 64'd0);
        chk("sg_f_rdata", f_rdata, 64'hF00D);
        f_req = 1'b0;
        tick();
        tick();
        chk("sg_m_resume_addr", mem_addr, 64'h320);
        chk("sg_m_resume_req", 64'(mem_req), 64'd1);
        mem_ack = 1'b1; mem_rdata = 64'h1;
        tick();
        mem_ack = 1'b0;
        chk("sg_m_resume_done", 64'(m_done), 64'd1);
        m_req = 1'b0;
        tick();

        // Out-of-range write: immediate error, no memory access.
        m_req = 1'b1; m_we = 1'b1; m_addr = 64'h1000; m_wdata = 64'hDEAD;
        #1 chk("ae_m_stall", 64'(m_mem_stall), 64'd1);
        tick();
        chk("ae_m_done", 64'(m_done), 64'd1);
        chk("ae_m_err", 64'(m_err), 64'd1);
        chk("ae_m_rdata", m_rdata, 64'd0);
        chk("ae_no_mem_req", 64'(mem_req), 64'd0);
        chk("ae_no_mem_we", 64'(mem_we), 64'd0);
        m_we = 1'b0; m_addr = 64'hFF8;
        tick();
        chk("ae_err_pulse", 64'(m_err), 64'd0);
        chk("ae_gap", 64'(mem_req), 64'd0);
        tick();
        chk("ae_rd_mem_addr", mem_addr, 64'hFF8);
        chk("ae_rd_mem_req", 64'(mem_req), 64'd1);
        mem_ack = 1'b1; mem_rdata = 64'h1234;
        tick();
        mem_ack = 1'b0;
        chk("ae_rd_done", 64'(m_done), 64'd1);
        chk("ae_rd_err", 64'(m_err), 64'd0);
        chk("ae_rd_rdata", m_rdata, 64'h1234);
        m_req = 1'b0;
        tick();

        // Slow memory write: 7 waiting cycles, one done, rdata held.
        m_req = 1'b1; m_we = 1'b1; m_addr = 64'h100; m_wdata = 64'hCAFE;
        tick();
        for (int k = 0; k < 7; k++) begin
            chk("sl_mem_req", 64'(mem_req), 64'd1);
            chk("sl_mem_addr", mem_addr, 64'h100);
            chk("sl_mem_we", 64'(mem_we), 64'd1);
            chk("sl_mem_wdata", mem_wdata, 64'hCAFE);
            chk("sl_stall", 64'(m_mem_stall), 64'd1);
            tick();
        end
        mem_ack = 1'b1; mem_rdata = 64'hBAD0;
        tick();
        mem_ack = 1'b0;
        chk("sl_done", 64'(m_done), 64'd1);
        chk("sl_rdata_held", m_rdata, 64'h1234);
        m_req = 1'b0;
        tick();
        chk("sl_single_pulse", 64'(m_done), 64'd0);

        // Reset in BUSY_M, late ack ignored, then a normal fetch.
        m_req = 1'b1; m_we = 1'b0; m_addr = 64'h80;
        tick();
        chk("rm_busy", 64'(mem_req), 64'd1);
        rst_n = 1'b0; m_req = 1'b0;
        tick();
        chk("rm_req_drop", 64'(mem_req), 64'd0);
        chk("rm_rdata_clr", m_rdata, 64'd0);
        rst_n = 1'b1;
        tick();
        tick();
        mem_ack = 1'b1; mem_rdata = 64'h9999;
        tick();
        mem_ack = 1'b0;
        chk("rm_no_m_done", 64'(m_done), 64'd0);
        chk("rm_no_f_done", 64'(f_done), 64'd0);
        chk("rm_m_rdata", m_rdata, 64'd0);
        f_req = 1'b1; f_addr = 64'h18;
        tick();
        chk("rm_f_mem_addr", mem_addr, 64'h18);
        mem_ack = 1'b1; mem_rdata = 64'h7777;
        tick();
        mem_ack = 1'b0;
        chk("rm_f_done", 64'(f_done), 64'd1);
        chk("rm_f_rdata", f_rdata, 64'h7777);
        f_req = 1'b0;
        tick();

        // Fetch address error with high address bits set.
        f_req = 1'b1; f_addr = 64'hFFFF_FFFF_FFFF_FFF0;
        tick();
        chk("fe_done", 64'(f_done), 64'd1);
        chk("fe_err", 64'(f_err), 64'd1);
        chk("fe_rdata", f_rdata, 64'd0);
        chk("fe_no_mem_req", 64'(mem_req), 64'd0);
        f_req = 1'b0;
        tick();
        chk("fe_err_pulse", 64'(f_err), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
